int_free_list: RTL

Circular-FIFO free list of integer physical registers. It sits directly upstream of the register alias table (RAT) in the rename stage and supplies up to `WAYS` free PRF indices per cycle. Entries come back at commit, when retiring instructions release their previous physical destination. Full pipeline flush is handled by a committed-head pointer; branch recovery uses optional head checkpoints.

---
 rtl/rename_pkg.sv | 14 +
 rtl/fl_head_checkpoint.sv | 26 ++
 rtl/int_free_list.sv | 91 +++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// rename_pkg: shared rename-stage sizes, index/pointer types and a popcount helper.
package rename_pkg;
    localparam int PRF_SIZE = 64;
    localparam int ARF_SIZE = 32;
    localparam int WAYS = 4;
    localparam int CP_NUM = 2;
    localparam int FL_DEPTH = PRF_SIZE - ARF_SIZE;
    typedef logic [$clog2(PRF_SIZE)-1:0] prf_idx_t;
    typedef logic [$clog2(FL_DEPTH):0] fl_ptr_t;
    function automatic int unsigned popcount(input logic [31:0] v);
        popcount = 0;
        for (int i = 0; i < 32; i++) popcount += 32'(v[i]);
    endfunction
endpackage

// File: rtl/fl_head_checkpoint.sv
// fl_head_checkpoint: small register file of speculative free-list head snapshots for branch recovery.
module fl_head_checkpoint
    import rename_pkg::*;
#(
    parameter int ENTRIES = CP_NUM,
    parameter int PTR_W = $bits(fl_ptr_t),
    parameter int IDX_W = $clog2(ENTRIES)
) (
    input  logic clock,
    input  logic reset,
    input  logic wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [PTR_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_index,
    output logic [PTR_W-1:0] rd_data
);
    logic [PTR_W-1:0] cp [ENTRIES];
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < ENTRIES; k++) cp[k] <= '0;
        end else if (wr_en) begin
            cp[wr_index] <= wr_data;
        end
    end
    assign rd_data = cp[rd_index];
endmodule

// File: rtl/int_free_list.sv
// int_free_list: circular-FIFO free list of integer PRF indices, up to WAYS all-or-nothing grants per cycle.
// Head checkpoints for branch recovery exist only when FREE_LIST_CHECKPOINT_EN is defined.
module int_free_list #(
    parameter int WAYS = rename_pkg::WAYS,
    parameter int PRF_SIZE = rename_pkg::PRF_SIZE,
    parameter int ARF_SIZE = rename_pkg::ARF_SIZE,
    parameter int DEPTH = PRF_SIZE - ARF_SIZE
`ifdef FREE_LIST_CHECKPOINT_EN
    ,
    parameter int CP_NUM = rename_pkg::CP_NUM
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic pause,
    input  logic recover,
    input  logic [WAYS-1:0] inst_req,
    output logic [WAYS-1:0][$clog2(PRF_SIZE)-1:0] prf,
    output logic allocatable,
    input  logic [WAYS-1:0] rel_valid,
    input  logic [WAYS-1:0][$clog2(PRF_SIZE)-1:0] rel_prf
`ifdef FREE_LIST_CHECKPOINT_EN
    ,
    input  logic check,
    input  logic [$clog2(CP_NUM)-1:0] check_index,
    input  logic restore,
    input  logic [$clog2(CP_NUM)-1:0] restore_index
`endif
);
    import rename_pkg::*;
    localparam int PW = $clog2(PRF_SIZE);
    localparam int AW = $clog2(DEPTH);
    localparam int PTR = AW + 1;
    logic [PW-1:0] entry [DEPTH];
    logic [PTR-1:0] spec_head, cmt_head, tail, count, n, m, ro, wo, alloc_head, next_head;
    logic [AW-1:0] wr_idx [WAYS];
    logic fire;
`ifdef FREE_LIST_CHECKPOINT_EN
    logic [PTR-1:0] cp_head;
    fl_head_checkpoint #(.ENTRIES(CP_NUM), .PTR_W(PTR)) u_cp (
        .clock(clock),
        .reset(reset),
        .wr_en(check & ~restore & ~recover),
        .wr_index(check_index),
        .wr_data(alloc_head),
        .rd_index(restore_index),
        .rd_data(cp_head)
    );
`endif
    always_comb begin
        n = PTR'(popcount(32'(inst_req)));
        m = PTR'(popcount(32'(rel_valid)));
        count = tail - spec_head;
        allocatable = count >= n;
        fire = allocatable & ~pause & ~recover;
        alloc_head = fire ? spec_head + n : spec_head;
        ro = '0;
        wo = '0;
        for (int i = 0; i < WAYS; i++) begin
            prf[i] = entry[AW'(spec_head + ro)];
            wr_idx[i] = AW'(tail + wo);
            ro = ro + PTR'(inst_req[i]);
            wo = wo + PTR'(rel_valid[i]);
        end
`ifdef FREE_LIST_CHECKPOINT_EN
        next_head = recover ? cmt_head + m : restore ? cp_head : alloc_head;
`else
        next_head = recover ? cmt_head + m : alloc_head;
`endif
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) entry[k] <= PW'(ARF_SIZE + k);
            spec_head <= '0;
            cmt_head <= '0;
            tail <= PTR'(DEPTH);
        end else begin
            for (int i = 0; i < WAYS; i++) if (rel_valid[i]) entry[wr_idx[i]] <= rel_prf[i];
            spec_head <= next_head;
            cmt_head <= cmt_head + m;
            tail <= tail + m;
        end
    end
    // Releases may only retire entries that were handed out and not yet committed.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (32'(count) + 32'(m) <= 32'(DEPTH));
            assert (PTR'(spec_head - cmt_head) >= m);
        end
    end
endmodule
